// File: rtl/prop_mon_pkg.sv
// prop_mon_pkg: shared types and default sizes for the temporal property monitor
package prop_mon_pkg;
  localparam int DEF_W = 7;
  localparam int DEF_MAX_DLY = 31;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_BW = $clog2(DEF_W);
  localparam int DEF_DW = $clog2(DEF_MAX_DLY + 1);
  typedef enum logic {SRC_IN, SRC_OUT} src_e;
  typedef enum logic {EDGE_RISE, EDGE_FALL} edge_e;
  typedef struct packed {
    src_e              ante_src;
    logic [DEF_BW-1:0] ante_bit;
    edge_e             ante_fall;
    src_e              cons_src;
    logic [DEF_BW-1:0] cons_bit;
    edge_e             cons_fall;
    logic [DEF_DW-1:0] min_dly;
    logic [DEF_DW-1:0] max_dly;
  } rule_cfg_t;
endpackage

// File: rtl/prop_edge_sel.sv
// prop_edge_sel: picks one bit of fsm_in/fsm_out and strobes on its selected edge polarity
module prop_edge_sel
  import prop_mon_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [W-1:0]         fsm_in,
  input  logic [W-1:0]         fsm_out,
  input  src_e                 src,
  input  logic [$clog2(W)-1:0] idx,
  input  edge_e                pol,
  output logic                 strobe
);
  logic [W-1:0] vec;
  logic cur, prev, valid;
  assign vec = src == SRC_OUT ? fsm_out : fsm_in;
  assign cur = vec[idx];
  // valid lags enable by one sample so the first enabled sample never reports an edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prev  <= 1'b0;
      valid <= 1'b0;
    end else begin
      prev  <= cur;
      valid <= enable;
    end
  assign strobe = enable & valid & (pol == EDGE_FALL ? prev & ~cur : cur & ~prev);
endmodule

// File: rtl/prop_window_monitor.sv
// prop_window_monitor: checks that an antecedent edge is followed by a consequent edge within [min:max] samples
module prop_window_monitor
  import prop_mon_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int MAX_DLY = DEF_MAX_DLY,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [W-1:0]                 fsm_in,
  input  logic [W-1:0]                 fsm_out,
  input  logic                         enable,
  input  logic                         cfg_load,
  input  logic                         ante_src,
  input  logic [$clog2(W)-1:0]         ante_bit,
  input  logic                         ante_fall,
  input  logic                         cons_src,
  input  logic [$clog2(W)-1:0]         cons_bit,
  input  logic                         cons_fall,
  input  logic [$clog2(MAX_DLY+1)-1:0] min_dly,
  input  logic [$clog2(MAX_DLY+1)-1:0] max_dly,
  output logic                         cfg_err,
  output logic                         pass_pulse,
  output logic                         fail_pulse,
  output logic [CNT_W-1:0]             pass_cnt,
  output logic [CNT_W-1:0]             fail_cnt,
  output logic                         busy
);
  localparam int PW = $clog2(MAX_DLY + 2);
  localparam logic [MAX_DLY:0] ONES = '1;
  rule_cfg_t rule;
  logic ae, ce, expd, illegal;
  logic [MAX_DLY:0] pend, age, win, keep, sat;
  logic [PW-1:0] pc;
  logic [CNT_W:0] psum, fsum;
  prop_edge_sel #(.W(W)) u_ante (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fsm_in(fsm_in), .fsm_out(fsm_out),
    .src(rule.ante_src), .idx(rule.ante_bit), .pol(rule.ante_fall), .strobe(ae)
  );
  prop_edge_sel #(.W(W)) u_cons (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fsm_in(fsm_in), .fsm_out(fsm_out),
    .src(rule.cons_src), .idx(rule.cons_bit), .pol(rule.cons_fall), .strobe(ce)
  );
  assign illegal = int'(min_dly) > int'(max_dly) || int'(max_dly) > MAX_DLY ||
                   int'(ante_bit) >= W || int'(cons_bit) >= W;
  // bit k of age is an attempt that started k samples ago, bit 0 being this sample
  always_comb begin
    age  = {pend[MAX_DLY-1:0], ae & ~cfg_err};
    win  = (ONES << rule.min_dly) & ~((ONES << rule.max_dly) << 1);
    keep = ~(ONES << rule.max_dly);
    sat  = ce ? age & win : '0;
    expd = age[rule.max_dly] & ~ce;
    pc   = '0;
    for (int k = 0; k <= MAX_DLY; k++) pc = pc + PW'(sat[k]);
    psum = {1'b0, pass_cnt} + (CNT_W+1)'(pc);
    fsum = {1'b0, fail_cnt} + (CNT_W+1)'(expd);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rule       <= '0;
      cfg_err    <= 1'b0;
      pend       <= '0;
      pass_pulse <= 1'b0;
      fail_pulse <= 1'b0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
    end else begin
      if (cfg_load && !enable) begin
        rule <= '{ante_src: src_e'(ante_src), ante_bit: ante_bit, ante_fall: edge_e'(ante_fall),
                  cons_src: src_e'(cons_src), cons_bit: cons_bit, cons_fall: edge_e'(cons_fall),
                  min_dly: min_dly, max_dly: max_dly};
        cfg_err <= illegal;
      end
      pend       <= enable ? age & ~sat & keep : '0;
      pass_pulse <= enable & |sat;
      fail_pulse <= enable & expd;
      if (enable) begin
        pass_cnt <= psum[CNT_W] ? '1 : psum[CNT_W-1:0];
        fail_cnt <= fsum[CNT_W] ? '1 : fsum[CNT_W-1:0];
      end
    end
  assign busy = |pend;
endmodule

// File: tb/tb_prop_window_monitor.sv
// tb_prop_window_monitor: directed and random checks against an attempt-list reference model
module tb_prop_window_monitor;
  logic clk = 0, rst_n = 0;
  logic [6:0] fsm_in = 0, fsm_out = 0;
  logic enable = 0, cfg_load = 0, ante_src = 0, ante_fall = 0, cons_src = 0, cons_fall = 0;
  logic [2:0] ante_bit = 0, cons_bit = 0;
  logic [4:0] min_dly = 0, max_dly = 0;
  logic cfg_err, pass_pulse, fail_pulse, busy;
  logic [15:0] pass_cnt, fail_cnt;
  int total = 0, bad = 0;
  int ages[$];
  logic [6:0] m_pi, m_po;
  bit m_valid, m_err, m_pp, m_fp, r_as, r_af, r_cs, r_cf;
  int r_ab, r_cb, r_min, r_max, m_pass, m_fail;

  always #5 clk = ~clk;

  prop_window_monitor dut (
    .clk(clk), .rst_n(rst_n), .fsm_in(fsm_in), .fsm_out(fsm_out), .enable(enable),
    .cfg_load(cfg_load), .ante_src(ante_src), .ante_bit(ante_bit), .ante_fall(ante_fall),
    .cons_src(cons_src), .cons_bit(cons_bit), .cons_fall(cons_fall),
    .min_dly(min_dly), .max_dly(max_dly), .cfg_err(cfg_err), .pass_pulse(pass_pulse),
    .fail_pulse(fail_pulse), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .busy(busy)
  );

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic bit edg(bit src, int b, bit fall);
    bit p = src ? m_po[b] : m_pi[b];
    bit c = src ? fsm_out[b] : fsm_in[b];
    return fall ? (p && !c) : (!p && c);
  endfunction

  task automatic m_reset();
    ages.delete();
    m_pi = 0; m_po = 0; m_valid = 0; m_err = 0; m_pp = 0; m_fp = 0;
    r_as = 0; r_af = 0; r_cs = 0; r_cf = 0; r_ab = 0; r_cb = 0; r_min = 0; r_max = 0;
    m_pass = 0; m_fail = 0;
  endtask

  task automatic model_step();
    bit a, c;
    m_pp = 0; m_fp = 0;
    if (!enable) begin
      if (cfg_load) begin
        r_as = ante_src; r_ab = ante_bit; r_af = ante_fall;
        r_cs = cons_src; r_cb = cons_bit; r_cf = cons_fall;
        r_min = min_dly; r_max = max_dly;
        m_err = r_min > r_max || r_ab >= 7 || r_cb >= 7;
      end
      ages.delete();
      m_valid = 0;
    end else begin
      a = m_valid && !m_err && edg(r_as, r_ab, r_af);
      c = m_valid && !m_err && edg(r_cs, r_cb, r_cf);
      foreach (ages[i]) ages[i]++;
      if (a) ages.push_back(0);
      for (int i = ages.size() - 1; i >= 0; i--)
        if (c && ages[i] >= r_min && ages[i] <= r_max) begin
          m_pass = m_pass >= 65535 ? 65535 : m_pass + 1;
          m_pp = 1;
          ages.delete(i);
        end else if (ages[i] >= r_max) begin
          m_fail = m_fail >= 65535 ? 65535 : m_fail + 1;
          m_fp = 1;
          ages.delete(i);
        end
      m_valid = 1;
    end
    m_pi = fsm_in; m_po = fsm_out;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("pass_pulse", pass_pulse, m_pp);
    chk("fail_pulse", fail_pulse, m_fp);
    chk("pass_cnt", pass_cnt, m_pass);
    chk("fail_cnt", fail_cnt, m_fail);
    chk("busy", busy, ages.size() != 0);
    chk("cfg_err", cfg_err, m_err);
  endtask

  task automatic drv(logic [6:0] i, logic [6:0] o);
    fsm_in = i; fsm_out = o;
    tick();
  endtask

  task automatic load(bit as_, int ab, bit af, bit cs, int cb, bit cf, int mn, int mx);
    enable = 0;
    ante_src = as_; ante_bit = 3'(ab); ante_fall = af;
    cons_src = cs; cons_bit = 3'(cb); cons_fall = cf;
    min_dly = 5'(mn); max_dly = 5'(mx);
    cfg_load = 1;
    tick();
    cfg_load = 0;
  endtask

  initial begin
    m_reset();
    #12;
    chk("rst_pass_pulse", pass_pulse, 0);
    chk("rst_fail_pulse", fail_pulse, 0);
    chk("rst_pass_cnt", pass_cnt, 0);
    chk("rst_fail_cnt", fail_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_err", cfg_err, 0);
    rst_n = 1;
    // in[6] rise -> out[1] rise within [3:4], consequent at age 3
    load(0, 6, 0, 1, 1, 0, 3, 4);
    enable = 1;
    drv(0, 0);
    drv(7'h40, 0);
    drv(7'h40, 0);
    drv(7'h40, 0);
    drv(7'h40, 7'h02);
    chk("t1_pass_pulse", pass_pulse, 1);
    chk("t1_pass_cnt", pass_cnt, 1);
    // consequent never arrives: expires at age 4
    drv(0, 0);
    drv(7'h40, 0);
    repeat (4) drv(7'h40, 0);
    chk("t2_fail_pulse", fail_pulse, 1);
    chk("t2_fail_cnt", fail_cnt, 1);
    chk("t2_busy", busy, 0);
    // two overlapping attempts satisfied by one consequent (ages 4 and 2)
    load(0, 6, 0, 1, 1, 0, 2, 4);
    enable = 1;
    drv(0, 0);
    drv(7'h40, 0);
    drv(0, 0);
    drv(7'h40, 0);
    drv(7'h40, 0);
    drv(7'h40, 7'h02);
    chk("t3_pass_pulse", pass_pulse, 1);
    chk("t3_pass_cnt", pass_cnt, 3);
    // illegal window min>max
    load(0, 6, 0, 1, 1, 0, 5, 2);
    chk("t4_cfg_err", cfg_err, 1);
    enable = 1;
    for (int i = 0; i < 10; i++) drv(i % 2 ? 7'h40 : 7'h00, i % 2 ? 7'h02 : 7'h00);
    chk("t4_busy", busy, 0);
    chk("t4_pass_cnt", pass_cnt, 3);
    chk("t4_fail_cnt", fail_cnt, 1);
    // enable dropped with an attempt at age 2
    load(0, 6, 0, 1, 1, 0, 3, 4);
    chk("t5_cfg_err", cfg_err, 0);
    enable = 1;
    drv(0, 0);
    drv(7'h40, 0);
    drv(7'h40, 0);
    drv(7'h40, 0);
    chk("t5_busy_before", busy, 1);
    enable = 0;
    tick();
    chk("t5_busy", busy, 0);
    chk("t5_fail_cnt", fail_cnt, 1);
    // saturation: preload pass_cnt, same-sample passes with min=max=0
    load(0, 6, 0, 0, 6, 0, 0, 0);
    force dut.pass_cnt = 16'hFFFE;
    #2;
    release dut.pass_cnt;
    m_pass = 16'hFFFE;
    enable = 1;
    drv(0, 0);
    repeat (3) begin
      drv(7'h40, 0);
      drv(0, 0);
    end
    chk("t6_pass_sat", pass_cnt, 16'hFFFF);
    // random rules and traffic
    for (int r = 0; r < 24; r++) begin
      int mx, mn;
      mx = $urandom_range(0, 31);
      mn = $urandom_range(0, 5) == 0 ? $urandom_range(0, 31) : $urandom_range(0, mx);
      load($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1),
           $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1), mn, mx);
      for (int c = 0; c < 120; c++) begin
        enable = $urandom_range(0, 49) != 0;
        cfg_load = enable && $urandom_range(0, 15) == 0;
        {ante_bit, cons_bit, min_dly, max_dly} = 16'($urandom);
        fsm_in = fsm_in ^ 7'($urandom & $urandom & $urandom);
        fsm_out = fsm_out ^ 7'($urandom & $urandom & $urandom);
        tick();
      end
      cfg_load = 0;
    end
    // async reset in the middle of a window
    load(0, 6, 0, 1, 1, 0, 3, 4);
    enable = 1;
    drv(0, 0);
    drv(7'h40, 0);
    drv(7'h40, 0);
    chk("t7_busy_before", busy, 1);
    #2;
    rst_n = 0;
    #1;
    chk("t7_pass_pulse", pass_pulse, 0);
    chk("t7_fail_pulse", fail_pulse, 0);
    chk("t7_pass_cnt", pass_cnt, 0);
    chk("t7_fail_cnt", fail_cnt, 0);
    chk("t7_busy", busy, 0);
    chk("t7_cfg_err", cfg_err, 0);
    m_reset();
    #2;
    rst_n = 1;
    drv(0, 0);
    drv(7'h01, 0);
    chk("t7_default_rule_pass", pass_cnt, 1);
    drv(0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
